// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and deglitch pins, check 11-bit frames, queue scan codes in a FWFT FIFO.
// Latency: stop-bit clock edge to rd_valid = 2 (sync) + FILTER_LEN (filter) + 2 (fall strobe, push) clk.
// Backpressure: none toward the device; a good frame arriving on a full FIFO is dropped and sets sticky overflow.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  input  logic                          rd_en,
  input  logic                          clr_ovf,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int FCW  = $clog2(FILTER_LEN + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // input conditioning state
  logic [1:0]     sync_clk_q, sync_clk_d;
  logic [1:0]     sync_dat_q, sync_dat_d;
  logic           filt_q, filt_d;
  logic           filt_prev_q, filt_prev_d;
  logic [FCW-1:0] flt_cnt_q, flt_cnt_d;
  // frame FSM state
  logic [1:0]     state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           par_ok_q, par_ok_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           push_q, push_d;
  logic           err_q, err_d;
  // FIFO state
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;

  logic fall;
  logic dat_s;
  logic pop;
  logic full;
  logic wr_ok;

  // Synchronise both pins; the filtered clock only follows after FILTER_LEN consecutive differing samples.
  always_comb begin
    sync_clk_d  = {sync_clk_q[0], ps2_clk};
    sync_dat_d  = {sync_dat_q[0], ps2_dat};
    filt_d      = filt_q;
    flt_cnt_d   = '0;
    filt_prev_d = filt_q;
    if (sync_clk_q[1] != filt_q) begin
      if (flt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = sync_clk_q[1];
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  assign fall  = filt_prev_q & ~filt_q;
  assign dat_s = sync_dat_q[1];

  // Frame FSM: advances on each filtered falling edge, aborts a stalled frame after TIMEOUT_CYC idle cycles.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_ok_d  = par_ok_q;
    push_d    = 1'b0;
    err_d     = 1'b0;
    if (state_q == ST_IDLE || fall) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shreg_d   = {dat_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_ok_d = ^{shreg_q, dat_s};
          state_d  = ST_STOP;
        end
        default: begin
          if (dat_s && par_ok_q) begin
            push_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  // FIFO: the received byte stays in shreg_q until the next frame's first data bit, so push_q can write it directly.
  always_comb begin
    pop      = rd_en && (count_q != '0);
    full     = (count_q == CNTW'(FIFO_DEPTH));
    wr_ok    = push_q && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = shreg_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNTW'(wr_ok) - CNTW'(pop);
    ovf_d   = ovf_q;
    if (push_q && full && !pop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State registers; the idle PS/2 bus is high, so synchronisers and filter reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_clk_q  <= 2'b11;
      sync_dat_q  <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      flt_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync_clk_q  <= sync_clk_d;
      sync_dat_q  <= sync_dat_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      flt_cnt_q   <= flt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_ok_q    <= par_ok_d;
      tmo_q       <= tmo_d;
      push_q      <= push_d;
      err_q       <= err_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rd_valid  = (count_q != '0);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: table-driven frames, hand-written corner sequences, random frames vs a queue model.
// Runs with a fast PS/2 clock and short timeout so the whole run stays small.
// Inputs driven 1 time unit after the rising edge; outputs checked there, away from the edge.
module tb_ps2_kbd_rx;

  localparam int DEPTH   = 8;
  localparam int FLEN    = 4;
  localparam int TMO     = 400;
  localparam int HALF    = 20;
  localparam int GAP     = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] count;
  logic       overflow;
  logic       frame_err;

  int n_checks = 0;
  int n_err    = 0;
  int err_cnt  = 0;

  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // frame_err is a one-cycle pulse; count pulses on the falling edge
  always @(negedge clk) if (frame_err) err_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // pop_at_push raises rd_en for exactly the cycle the byte is pushed (8 clk after the stop-bit fall)
  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_bad,
                            input bit start_bad, input bit pop_at_push);
    logic par;
    par = ((($countones(d) % 2) == 0) ? 1'b1 : 1'b0) ^ par_flip;
    send_bit(start_bad);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    ps2_dat = ~stop_bad;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    if (pop_at_push) begin
      wait_cyc(7);
      rd_en = 1'b1;
      wait_cyc(1);
      rd_en = 1'b0;
      wait_cyc(HALF - 8);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic pop1;
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         par_flip;
    bit         stop_bad;
    bit         start_bad;
    int         exp_inc;
    int         exp_errs;
  } vec_t;

  vec_t vecs [8];
  logic [7:0] mq [$];

  initial begin
    int e0;
    int c0;
    logic [7:0] d;
    int kind;
    bit good;
    logic par;
    int npop;

    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1, 0};
    vecs[1] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1, 0};
    vecs[2] = '{8'h1C, 1'b1, 1'b0, 1'b0, 0, 1};
    vecs[3] = '{8'h1C, 1'b0, 1'b1, 1'b0, 0, 1};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 1, 0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1, 0};
    vecs[6] = '{8'h81, 1'b1, 1'b1, 1'b0, 0, 1};
    vecs[7] = '{8'h1C, 1'b0, 1'b0, 1'b1, 0, 1};

    // reset state
    wait_cyc(3);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset count", count, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset overflow", overflow, 0);
    chk("reset frame_err", frame_err, 0);
    rst_n = 1'b1;
    wait_cyc(10);

    // single good frame 0x1C
    e0 = err_cnt;
    send_frame(8'h1C, 0, 0, 0, 0);
    chk("t1 rd_valid", rd_valid, 1);
    chk("t1 count", count, 1);
    chk("t1 rd_data", rd_data, 8'h1C);
    chk("t1 no frame_err", err_cnt - e0, 0);
    pop1();
    chk("t1 empty after pop", count, 0);

    // vector table
    for (int i = 0; i < 8; i++) begin
      e0 = err_cnt;
      c0 = int'(count);
      send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop_bad, vecs[i].start_bad, 0);
      if (vecs[i].start_bad) wait_cyc(TMO + 50);
      chk($sformatf("vec%0d count", i), count, c0 + vecs[i].exp_inc);
      chk($sformatf("vec%0d errs", i), err_cnt - e0, vecs[i].exp_errs);
      if (vecs[i].exp_inc == 1) begin
        chk($sformatf("vec%0d data", i), rd_data, vecs[i].data);
        pop1();
      end
    end

    // two frames queued, read back in order
    send_frame(8'hF0, 0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0, 0);
    chk("t2 count", count, 2);
    chk("t2 head F0", rd_data, 8'hF0);
    pop1();
    chk("t2 head 1C", rd_data, 8'h1C);
    pop1();
    chk("t2 empty data", rd_data, 8'h00);
    chk("t2 empty valid", rd_valid, 0);
    pop1();
    chk("t2 pop on empty ignored", count, 0);

    // short glitches on ps2_clk while idle
    e0 = err_cnt;
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    wait_cyc(TMO + 20);
    chk("glitch errs", err_cnt - e0, 0);
    chk("glitch count", count, 0);
    send_frame(8'h33, 0, 0, 0, 0);
    chk("after glitch data", rd_data, 8'h33);
    pop1();

    // timeout: start + 3 data bits then clock held high
    e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_dat = 1'b1;
    wait_cyc(TMO / 2);
    chk("tmo not yet", err_cnt - e0, 0);
    wait_cyc(TMO);
    chk("tmo err", err_cnt - e0, 1);
    chk("tmo count", count, 0);
    send_frame(8'h5A, 0, 0, 0, 0);
    chk("after tmo data", rd_data, 8'h5A);
    chk("after tmo errs", err_cnt - e0, 1);
    pop1();

    // overflow with nine frames
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 0, 0, 0, 0);
    chk("ovf count", count, DEPTH);
    chk("ovf flag", overflow, 1);
    chk("ovf head", rd_data, 8'h01);
    clr_ovf = 1'b1;
    wait_cyc(1);
    clr_ovf = 1'b0;
    chk("ovf cleared", overflow, 0);
    send_frame(8'h0A, 0, 0, 0, 1);
    chk("full push+pop count", count, DEPTH);
    chk("full push+pop no ovf", overflow, 0);
    for (int k = 2; k <= 9; k++) begin
      d = (k == 9) ? 8'h0A : 8'(k);
      chk($sformatf("drain %0d", k), rd_data, d);
      pop1();
    end
    chk("drained empty", rd_valid, 0);

    // random frames against a queue model
    for (int i = 0; i < 30; i++) begin
      d    = 8'($urandom);
      kind = int'($urandom_range(0, 3));
      e0   = err_cnt;
      send_frame(d, kind == 2, kind == 3, 0, 0);
      par  = ((($countones(d) % 2) == 0) ? 1'b1 : 1'b0) ^ (kind == 2);
      good = (($countones({d, par}) % 2) == 1) && (kind != 3);
      if (good) mq.push_back(d);
      chk($sformatf("rnd%0d errs", i), err_cnt - e0, good ? 0 : 1);
      chk($sformatf("rnd%0d count", i), count, mq.size());
      npop = (mq.size() >= 6) ? 3 : int'($urandom_range(0, 2));
      for (int p = 0; p < npop; p++) begin
        if (mq.size() > 0) begin
          chk($sformatf("rnd%0d data", i), rd_data, mq[0]);
          void'(mq.pop_front());
          pop1();
        end
      end
    end
    while (mq.size() > 0) begin
      chk("rnd drain", rd_data, mq[0]);
      void'(mq.pop_front());
      pop1();
    end
    chk("rnd final empty", count, 0);

    // reset mid-frame with a byte queued, then resync
    send_frame(8'h44, 0, 0, 0, 0);
    chk("pre-reset valid", rd_valid, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    #2;
    chk("rst rd_valid", rd_valid, 0);
    chk("rst count", count, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst overflow", overflow, 0);
    chk("rst frame_err", frame_err, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_dat = 1'b1;
    wait_cyc(TMO + 50);
    send_frame(8'h29, 0, 0, 0, 0);
    chk("resync count", count, 1);
    chk("resync data", rd_data, 8'h29);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
